// File: rtl/mul_16_bits.sv
// Sequential 16x16 unsigned shift-add multiplier with start/done handshake.
// One carry-select adder iteration per cycle; 16 iterations per product.

module csa_16_bits (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] s,
    output logic        c
);
    logic [8:0] lo_sum;
    logic [8:0] hi_sum0;
    logic [8:0] hi_sum1;

    // Upper byte is precomputed for both carry-ins, then selected.
    assign lo_sum  = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'd0, c_in};
    assign hi_sum0 = {1'b0, a[15:8]} + {1'b0, b[15:8]};
    assign hi_sum1 = {1'b0, a[15:8]} + {1'b0, b[15:8]} + 9'd1;

    always_comb begin
        s[7:0] = lo_sum[7:0];
        if (lo_sum[8]) begin
            s[15:8] = hi_sum1[7:0];
            c       = hi_sum1[8];
        end else begin
            s[15:8] = hi_sum0[7:0];
            c       = hi_sum0[8];
        end
    end
endmodule

module mul_16_bits (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] mcand_q;
    logic [15:0] hi_q;
    logic [15:0] lo_q;
    logic [3:0]  cnt_q;
    logic [31:0] product_q;

    logic [15:0] sum;
    logic        carry;
    logic [31:0] shift_d;

    csa_16_bits u_csa (
        .a    (hi_q),
        .b    (mcand_q),
        .c_in (1'b0),
        .s    (sum),
        .c    (carry)
    );

    // Add-then-shift when the low multiplier bit is set, plain shift otherwise.
    always_comb begin
        shift_d = {1'b0, hi_q, lo_q[15:1]};
        if (lo_q[0]) begin
            shift_d = {carry, sum, lo_q[15:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= 16'd0;
            hi_q      <= 16'd0;
            lo_q      <= 16'd0;
            cnt_q     <= 4'd0;
            product_q <= 32'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        mcand_q <= a;
                        hi_q    <= 16'd0;
                        lo_q    <= b;
                        cnt_q   <= 4'd0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    hi_q  <= shift_d[31:16];
                    lo_q  <= shift_d[15:0];
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        product_q <= shift_d;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = product_q;
endmodule

// File: tb/tb_mul_16_bits.sv
// Randomized self-checking bench for mul_16_bits.
// Reference result is plain a*b; handshake timing checked by cycle counts.

module tb_mul_16_bits;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int checks;
    int failures;
    int cyc;

    mul_16_bits dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, optionally inject a stray start at cycle inj,
    // then check busy length, done timing and the product.
    task automatic do_mul(input logic [15:0] xa, input logic [15:0] xb,
                          input int inj, input string tag);
        logic [31:0] exp;
        int j;
        int bc;
        exp = {16'd0, xa} * {16'd0, xb};
        a = xa;
        b = xb;
        start = 1'b1;
        tick();
        start = 1'b0;
        j = 0;
        bc = 0;
        while (!done && j < 40) begin
            if (busy) bc++;
            if (j == inj) begin
                start = 1'b1;
                a = 16'd2;
                b = 16'd2;
            end
            if (j == inj + 3) start = 1'b0;
            tick();
            j++;
        end
        chk({tag, "_done_cyc"}, j, 16);
        chk({tag, "_busy_len"}, bc, 16);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_product"}, product, exp);
        tick();
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        tick();
        chk({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
        chk({tag, "_product_hold"}, product, exp);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [31:0] exp;
        int prev;
        int w;
        int seen;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        start = 1'b1;
        a = 16'hFFFF;
        b = 16'hFFFF;
        tick();
        tick();
        chk("rst_product", product, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        tick();

        do_mul(16'd3, 16'd5, -1, "m3x5");
        do_mul(16'hFFFF, 16'hFFFF, -1, "mffff");
        do_mul(16'h1234, 16'h0000, -1, "mzero_b");
        do_mul(16'h0000, 16'hABCD, -1, "mzero_a");
        do_mul(16'd7, 16'd9, 5, "mstray");
        chk("stray_no_run", {31'd0, busy}, 32'd0);

        // Reset in the middle of a run abandons it.
        a = 16'h00FF;
        b = 16'h0100;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_product", product, 32'd0);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (done || busy) seen = 1;
            tick();
        end
        chk("midrst_no_done", seen, 0);
        do_mul(16'd2, 16'd3, -1, "post_rst");

        for (int k = 0; k < 6; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            do_mul(ra, rb, -1, "rand");
        end

        // Back-to-back with start held high.
        ra = 16'($urandom);
        rb = 16'($urandom);
        a = ra;
        b = rb;
        start = 1'b1;
        prev = 0;
        for (int i = 0; i < 20; i++) begin
            w = 0;
            while (!busy && w < 40) begin
                tick();
                w++;
            end
            chk("b2b_accept_timeout", {31'd0, busy}, 32'd1);
            if (i > 0) chk("b2b_interval", cyc - prev, 18);
            prev = cyc;
            exp = {16'd0, ra} * {16'd0, rb};
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 4 == 0) begin
                ra = 16'hFFFF;
            end
            a = ra;
            b = rb;
            w = 0;
            while (!done && w < 40) begin
                tick();
                w++;
            end
            chk("b2b_done_timeout", {31'd0, done}, 32'd1);
            chk("b2b_product", product, exp);
        end
        start = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
